// File: rtl/substitution_layer_iter.sv
// Iterative ASCON substitution layer: NB_SBOX S-box columns per clock,
// walking all 64 columns of the 320-bit state under a start/done handshake.
package substitution_layer_pkg;
    typedef struct packed {
        logic [63:0] x0;
        logic [63:0] x1;
        logic [63:0] x2;
        logic [63:0] x3;
        logic [63:0] x4;
    } type_state;
endpackage

module substitution_layer_iter
    import substitution_layer_pkg::*;
#(
    parameter int NB_SBOX = 8
) (
    input  logic      clock_i,
    input  logic      resetb_i,
    input  logic      start_i,
    input  type_state state_i,
    output logic      busy_o,
    output logic      done_o,
    output logic      valid_o,
    output type_state state_o
);

    localparam int NB_ITER = 64 / NB_SBOX;
    localparam int CW      = (NB_ITER > 1) ? $clog2(NB_ITER) : 1;
    localparam int SH      = $clog2(NB_SBOX);

    if (NB_SBOX < 1 || NB_SBOX > 64 || (NB_SBOX & (NB_SBOX - 1)) != 0) begin : g_bad_nb
        $error("NB_SBOX must be a power of two between 1 and 64");
    end

    localparam logic [4:0] SBOX [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };

    typedef enum logic {IDLE, RUN} fsm_t;

    fsm_t        fsm;
    fsm_t        fsm_nxt;
    logic [CW-1:0] col_cnt;
    logic        last;
    logic [5:0]  base;
    logic [5:0]  idx;
    logic [4:0]  sb_in;
    logic [4:0]  sb_out;
    type_state   sub;

    assign last = (col_cnt == CW'(NB_ITER - 1));

    // Substitute the current chunk of columns; all other columns pass through.
    always_comb begin
        base   = 6'(col_cnt) << SH;
        sub    = state_o;
        idx    = '0;
        sb_in  = '0;
        sb_out = '0;
        for (int j = 0; j < NB_SBOX; j++) begin
            idx    = base + 6'(j);
            sb_in  = {state_o.x0[idx], state_o.x1[idx], state_o.x2[idx],
                      state_o.x3[idx], state_o.x4[idx]};
            sb_out = SBOX[sb_in];
            sub.x0[idx] = sb_out[4];
            sub.x1[idx] = sb_out[3];
            sub.x2[idx] = sb_out[2];
            sub.x3[idx] = sb_out[1];
            sub.x4[idx] = sb_out[0];
        end
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) fsm <= IDLE;
        else           fsm <= fsm_nxt;
    end

    always_comb begin
        fsm_nxt = fsm;
        unique case (fsm)
            IDLE:    if (start_i) fsm_nxt = RUN;
            RUN:     if (last)    fsm_nxt = IDLE;
            default: fsm_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy_o = (fsm == RUN);
    end

    always_ff @(posedge clock_i or negedge resetb_i) begin
        if (!resetb_i) begin
            col_cnt <= '0;
            state_o <= '0;
            done_o  <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            done_o <= 1'b0;
            unique case (fsm)
                IDLE: begin
                    if (start_i) begin
                        state_o <= state_i;
                        col_cnt <= '0;
                        valid_o <= 1'b0;
                    end
                end
                RUN: begin
                    state_o <= sub;
                    if (last) begin
                        col_cnt <= '0;
                        done_o  <= 1'b1;
                        valid_o <= 1'b1;
                    end else begin
                        col_cnt <= col_cnt + 1'b1;
                    end
                end
                default: col_cnt <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_substitution_layer_iter.sv
// Bench for substitution_layer_iter: three widths (1, 8, 64 S-boxes)
// checked against a column-by-column p_S reference model.
module tb_substitution_layer_iter;
    import substitution_layer_pkg::*;

    localparam logic [4:0] SB [32] = '{
        5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
        5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
        5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
        5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17
    };
    localparam int NBI [3] = '{64, 8, 1};

    logic      clk = 1'b0;
    logic      rstb = 1'b0;
    logic      start [3];
    type_state sin;
    logic      busy [3];
    logic      done [3];
    logic      valid [3];
    type_state sout [3];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    substitution_layer_iter #(.NB_SBOX(1)) u1 (
        .clock_i(clk), .resetb_i(rstb), .start_i(start[0]), .state_i(sin),
        .busy_o(busy[0]), .done_o(done[0]), .valid_o(valid[0]), .state_o(sout[0])
    );
    substitution_layer_iter #(.NB_SBOX(8)) u8 (
        .clock_i(clk), .resetb_i(rstb), .start_i(start[1]), .state_i(sin),
        .busy_o(busy[1]), .done_o(done[1]), .valid_o(valid[1]), .state_o(sout[1])
    );
    substitution_layer_iter #(.NB_SBOX(64)) u64 (
        .clock_i(clk), .resetb_i(rstb), .start_i(start[2]), .state_i(sin),
        .busy_o(busy[2]), .done_o(done[2]), .valid_o(valid[2]), .state_o(sout[2])
    );

    function automatic type_state ps(input type_state s);
        type_state  r;
        logic [4:0] v;
        logic [4:0] y;
        r = s;
        for (int i = 0; i < 64; i++) begin
            v = {s.x0[i], s.x1[i], s.x2[i], s.x3[i], s.x4[i]};
            y = SB[v];
            {r.x0[i], r.x1[i], r.x2[i], r.x3[i], r.x4[i]} = y;
        end
        return r;
    endfunction

    function automatic type_state rand_state();
        return {$urandom, $urandom, $urandom, $urandom, $urandom,
                $urandom, $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic run_one(input int k, input type_state s,
                           output type_state r, output int lat);
        @(negedge clk);
        sin = s;
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        lat = -1;
        for (int c = 1; c <= 200; c++) begin
            @(negedge clk);
            if (done[k]) begin
                lat = c;
                break;
            end
        end
        r = sout[k];
    endtask

    task automatic test_reset();
        rstb = 1'b0;
        sin = '0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            total++;
            if (busy[k] !== 1'b0 || done[k] !== 1'b0 || valid[k] !== 1'b0 || sout[k] !== '0) begin
                bad++;
                $display("FAIL reset k=%0d busy=%b done=%b valid=%b state=%h want all 0",
                         k, busy[k], done[k], valid[k], sout[k]);
            end
        end
        rstb = 1'b1;
    endtask

    task automatic test_zero();
        type_state r, exp;
        int lat;
        exp = '0;
        exp.x2 = 64'hFFFF_FFFF_FFFF_FFFF;
        run_one(1, '0, r, lat);
        total++;
        if (lat !== 8) begin
            bad++; $display("FAIL zero_latency got=%0d want=8", lat);
        end
        total++;
        if (r !== exp) begin
            bad++; $display("FAIL zero_state got=%h want=%h", r, exp);
        end
        total++;
        if (valid[1] !== 1'b1) begin
            bad++; $display("FAIL zero_valid got=%b want=1", valid[1]);
        end
        @(negedge clk);
        total++;
        if (done[1] !== 1'b0 || valid[1] !== 1'b1 || sout[1] !== exp) begin
            bad++;
            $display("FAIL zero_hold done=%b valid=%b state=%h want done=0 valid=1 state=%h",
                     done[1], valid[1], sout[1], exp);
        end
    endtask

    task automatic test_ones();
        type_state r, exp;
        int lat;
        exp = '1;
        exp.x1 = '0;
        run_one(1, '1, r, lat);
        total++;
        if (lat !== 8 || r !== exp) begin
            bad++; $display("FAIL ones lat=%0d state=%h want lat=8 state=%h", lat, r, exp);
        end
    endtask

    task automatic test_columns();
        type_state s, exp, r;
        int lat;
        logic [4:0] v;
        for (int i = 0; i < 64; i++) begin
            v = 5'(i % 32);
            {s.x0[i], s.x1[i], s.x2[i], s.x3[i], s.x4[i]} = v;
            {exp.x0[i], exp.x1[i], exp.x2[i], exp.x3[i], exp.x4[i]} = SB[v];
        end
        for (int k = 0; k < 3; k++) begin
            run_one(k, s, r, lat);
            total++;
            if (lat !== NBI[k]) begin
                bad++; $display("FAIL columns_latency k=%0d got=%0d want=%0d", k, lat, NBI[k]);
            end
            total++;
            if (r !== exp) begin
                bad++; $display("FAIL columns_state k=%0d got=%h want=%h", k, r, exp);
            end
        end
    endtask

    task automatic test_start_held();
        type_state s1, s2, r1, r2;
        int d1, d2, extra;
        s1 = rand_state();
        s2 = rand_state();
        d1 = -1; d2 = -1; extra = 0;
        r1 = '0; r2 = '0;
        @(negedge clk);
        sin = s1;
        start[1] = 1'b1;
        @(negedge clk);
        sin = s2;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (done[1]) begin
                if (d1 < 0) begin
                    d1 = c; r1 = sout[1];
                end else begin
                    d2 = c; r2 = sout[1];
                    start[1] = 1'b0;
                    break;
                end
            end
        end
        start[1] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done[1]) extra++;
        end
        total++;
        if (d1 !== 8 || d2 !== 17) begin
            bad++; $display("FAIL held_timing first=%0d second=%0d want 8 and 17", d1, d2);
        end
        total++;
        if (r1 !== ps(s1)) begin
            bad++; $display("FAIL held_first got=%h want=%h", r1, ps(s1));
        end
        total++;
        if (r2 !== ps(s2)) begin
            bad++; $display("FAIL held_second got=%h want=%h", r2, ps(s2));
        end
        total++;
        if (extra !== 0) begin
            bad++; $display("FAIL held_extra_done got=%0d want=0", extra);
        end
    endtask

    task automatic test_reset_mid();
        type_state s, r;
        int lat, dn;
        s = rand_state();
        @(negedge clk);
        sin = s;
        start[1] = 1'b1;
        @(negedge clk);
        start[1] = 1'b0;
        repeat (3) @(negedge clk);
        rstb = 1'b0;
        #1;
        total++;
        if (busy[1] !== 1'b0 || done[1] !== 1'b0 || valid[1] !== 1'b0 || sout[1] !== '0) begin
            bad++;
            $display("FAIL midreset busy=%b done=%b valid=%b state=%h want all 0",
                     busy[1], done[1], valid[1], sout[1]);
        end
        @(negedge clk);
        rstb = 1'b1;
        dn = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (done[1] || busy[1]) dn++;
        end
        total++;
        if (dn !== 0) begin
            bad++; $display("FAIL midreset_quiet activity_cycles=%0d want=0", dn);
        end
        s = rand_state();
        run_one(1, s, r, lat);
        total++;
        if (lat !== 8 || r !== ps(s)) begin
            bad++; $display("FAIL midreset_rerun lat=%0d state=%h want lat=8 state=%h", lat, r, ps(s));
        end
    endtask

    task automatic test_back_to_back(input int k, input int runs);
        type_state cur;
        bit found;
        cur = rand_state();
        @(negedge clk);
        sin = cur;
        start[k] = 1'b1;
        @(negedge clk);
        for (int r = 0; r < runs; r++) begin
            found = 1'b0;
            for (int c = 0; c < 200; c++) begin
                if (done[k]) begin
                    found = 1'b1;
                    break;
                end
                total++;
                if (valid[k] !== 1'b0 || busy[k] !== 1'b1) begin
                    bad++;
                    $display("FAIL b2b_run k=%0d run=%0d valid=%b busy=%b want valid=0 busy=1",
                             k, r, valid[k], busy[k]);
                end
                @(negedge clk);
            end
            total++;
            if (!found) begin
                bad++; $display("FAIL b2b_timeout k=%0d run=%0d done=0 want=1", k, r);
                break;
            end
            total++;
            if (sout[k] !== ps(cur) || valid[k] !== 1'b1) begin
                bad++;
                $display("FAIL b2b_state k=%0d run=%0d valid=%b got=%h want=%h",
                         k, r, valid[k], sout[k], ps(cur));
            end
            cur = rand_state();
            sin = cur;
            if (r == runs - 1) start[k] = 1'b0;
            @(negedge clk);
        end
        start[k] = 1'b0;
        repeat (70) @(negedge clk);
    endtask

    initial begin
        start[0] = 1'b0;
        start[1] = 1'b0;
        start[2] = 1'b0;
        test_reset();
        test_zero();
        test_ones();
        test_columns();
        test_start_held();
        test_reset_mid();
        test_back_to_back(1, 1000);
        test_back_to_back(2, 100);
        test_back_to_back(0, 20);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
